bit_serializer: RTL and testbench

//   Parallel-to-serial stage feeding the Moore sequence detector's 1-bit serial input.

---
 rtl/ser_pkg.sv | 23 ++
 rtl/bit_serializer.sv | 160 ++++++++++++++++
 tb/tb_bit_serializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ser_pkg
//  Description : Shared types and helpers for the bit serializer: FSM state
//                encoding and the bit-counter width calculation.
//  Revision    : 1.0  initial release
// ============================================================================
package ser_pkg;

  // S_PARITY is reachable only when SER_PARITY_EN is defined
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } ser_state_t;

  // Counter must be able to hold WIDTH (the parity-cycle index)
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial stage. Accepts a WIDTH-bit word over a
//                valid/ready handshake and emits it MSB-first, one bit per
//                clk, with registered ser_out / ser_valid / last. Back-to-back
//                words run with no idle gap. The idle line value is 0.
//                Optional macro SER_PARITY_EN appends one even-parity bit
//                after the LSB; last then marks the parity cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);
`ifdef SER_PARITY_EN
  localparam logic [CNT_W-1:0] c_par_idx  = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] c_pen_idx  = CNT_W'(WIDTH - 2);
`endif

  // The state names the bit currently on ser_out; r_cnt is that bit's index.
  ser_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_ser_out,   w_ser_out_nxt;
  logic             r_ser_valid, w_ser_valid_nxt;
  logic             r_last,      w_last_nxt;
  logic             r_par,       w_par_nxt;
  logic             w_final;
  logic             w_accept;

`ifdef SER_PARITY_EN
  assign w_final = (r_state == S_PARITY);
`else
  assign w_final = (r_state == S_SHIFT) && (r_cnt == c_last_idx);
`endif

  // Ready is gated by clear_n so nothing is taken while reset is held
  assign load_ready = clear_n && ((r_state == S_IDLE) || w_final);
  assign w_accept   = load_valid && load_ready;

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign last      = r_last;
  assign busy      = (r_state != S_IDLE);

  // Next-state and next-output decode; idle values are the default exit path
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_ser_out_nxt   = r_ser_out;
    w_ser_valid_nxt = r_ser_valid;
    w_last_nxt      = r_last;
    w_par_nxt       = r_par;

    if (w_accept) begin
      // MSB goes straight to the output register; the rest waits in r_shift
      w_state_nxt     = S_SHIFT;
      w_ser_out_nxt   = load_data[WIDTH-1];
      w_shift_nxt     = {load_data[WIDTH-2:0], 1'b0};
      w_cnt_nxt       = '0;
      w_ser_valid_nxt = 1'b1;
      w_last_nxt      = 1'b0;
      w_par_nxt       = ^load_data;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_cnt == c_last_idx) begin
`ifdef SER_PARITY_EN
            w_state_nxt     = S_PARITY;
            w_ser_out_nxt   = r_par;
            w_cnt_nxt       = c_par_idx;
            w_ser_valid_nxt = 1'b1;
            w_last_nxt      = 1'b1;
`else
            w_state_nxt     = S_IDLE;
            w_shift_nxt     = '0;
            w_cnt_nxt       = '0;
            w_ser_out_nxt   = 1'b0;
            w_ser_valid_nxt = 1'b0;
            w_last_nxt      = 1'b0;
`endif
          end else begin
            w_ser_out_nxt   = r_shift[WIDTH-1];
            w_shift_nxt     = {r_shift[WIDTH-2:0], 1'b0};
            w_cnt_nxt       = r_cnt + CNT_W'(1);
            w_ser_valid_nxt = 1'b1;
`ifdef SER_PARITY_EN
            w_last_nxt      = 1'b0;
`else
            w_last_nxt      = (r_cnt == c_pen_idx);
`endif
          end
        end
        S_PARITY, S_IDLE: begin
          w_state_nxt     = S_IDLE;
          w_shift_nxt     = '0;
          w_cnt_nxt       = '0;
          w_ser_out_nxt   = 1'b0;
          w_ser_valid_nxt = 1'b0;
          w_last_nxt      = 1'b0;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_shift_nxt     = '0;
          w_cnt_nxt       = '0;
          w_ser_out_nxt   = 1'b0;
          w_ser_valid_nxt = 1'b0;
          w_last_nxt      = 1'b0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register, bit counter and registered serial outputs
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_last      <= 1'b0;
      r_par       <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_last      <= w_last_nxt;
      r_par       <= w_par_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Directed self-checking bench for bit_serializer (WIDTH=10).
//                Honours SER_PARITY_EN to expect the extra parity cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

  localparam int WIDTH = 10;
`ifdef SER_PARITY_EN
  localparam int c_per = WIDTH + 1;
`else
  localparam int c_per = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             clear_n;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             last;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .last       (last),
    .busy       (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(ser_valid),  32'd0);
    chk({tag, "_out"},   32'(ser_out),    32'd0);
    chk({tag, "_last"},  32'(last),       32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd1);
  endtask

  // Called #1 after the accepting edge; walks every bit of the word
  task automatic run_word(input string tag, input logic [WIDTH-1:0] w,
                          input logic mv, input logic [WIDTH-1:0] md,
                          input logic ev, input logic [WIDTH-1:0] ed);
    logic exp_bit;
    for (int k = 0; k < c_per; k++) begin
      exp_bit = (k < WIDTH) ? w[WIDTH-1-k] : ^w;
      chk($sformatf("%s_bit%0d", tag, k),   32'(ser_out),    32'(exp_bit));
      chk($sformatf("%s_valid%0d", tag, k), 32'(ser_valid),  32'd1);
      chk($sformatf("%s_last%0d", tag, k),  32'(last),       32'(k == c_per - 1));
      chk($sformatf("%s_ready%0d", tag, k), 32'(load_ready), 32'(k == c_per - 1));
      chk($sformatf("%s_busy%0d", tag, k),  32'(busy),       32'd1);
      if (k == c_per - 1) begin
        load_valid = ev;
        load_data  = ed;
      end else begin
        load_valid = mv;
        load_data  = md;
      end
      @(posedge clk); #1;
    end
  endtask

  // Present a word and let the next edge accept it
  task automatic accept(input logic [WIDTH-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with load_valid asserted
    clear_n    = 1'b0;
    load_valid = 1'b1;
    load_data  = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ser_valid),  32'd0);
    chk("rst_out",   32'(ser_out),    32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_last",  32'(last),       32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    chk("rel_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_rel");

    // Single word
    accept(10'b1011001011);
    run_word("single", 10'b1011001011, 1'b0, '0, 1'b0, '0);
    chk_idle("single_end");

    // Back-to-back: valid held throughout
    accept(10'h2AA);
    run_word("b2b_a", 10'h2AA, 1'b1, 10'h155, 1'b1, 10'h155);
    run_word("b2b_b", 10'h155, 1'b0, '0, 1'b0, '0);
    chk_idle("b2b_end");

    // Stall: new data offered mid-word is ignored
    accept(10'h0F0);
    run_word("stall", 10'h0F0, 1'b1, 10'h3FF, 1'b0, '0);
    chk_idle("stall_end");

    // Mid-word reset at bit index 5
    accept(10'b1011001011);
    load_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_pre_valid", 32'(ser_valid), 32'd1);
    chk("mid_pre_bit5",  32'(ser_out),   32'd0);
    load_data = 10'b1011001011;
    clear_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ser_valid),  32'd0);
    chk("mid_rst_out",   32'(ser_out),    32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_last",  32'(last),       32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd0);
    #3;
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("mid_idle%0d", i));
    end

    // Word with a single 1 (odd parity source when enabled)
    accept(10'b0000000001);
    run_word("one", 10'b0000000001, 1'b0, '0, 1'b0, '0);
    chk_idle("one_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
